// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: multi-cycle RV32M multiply/divide sequencer.
// Ports: clk, reset, start, funct3, SrcA, SrcB, kill -> busy, stall, done, Result.
module muldiv_seq_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic                  kill,
   output logic                  busy,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] Result
);

   localparam int W = DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [2:0]           r_f3;
   logic [W-1:0]         r_opa;
   logic [W-1:0]         r_opb;
   logic [2*W-1:0]       r_acc;
   logic                 r_neg;
   logic [W-1:0]         r_result;
   logic                 r_busy;
   logic                 r_done;

   logic         w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic         w_is_div, w_is_rem, w_div0, w_ovf, w_neg_rec;
   logic [W-1:0] w_mag_a, w_mag_b, w_fast;
   logic [W:0]   w_msum;
   logic [W:0]   w_rsh;
   logic [W-1:0] w_sub;
   logic         w_ge;
   logic [2*W-1:0] w_prod;
   logic [W-1:0] w_dsel, w_dres, w_fix;

   // Signedness per operand: MULH/DIV/REM sign both, MULHSU only rs1.
   assign w_sgn_a = (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_sgn_b = (funct3 == 3'b001) | (funct3 == 3'b100) |
                    (funct3 == 3'b110);
   assign w_neg_a = w_sgn_a & SrcA[W-1];
   assign w_neg_b = w_sgn_b & SrcB[W-1];
   assign w_mag_a = w_neg_a ? -SrcA : SrcA;
   assign w_mag_b = w_neg_b ? -SrcB : SrcB;

   assign w_is_div = funct3[2];
   assign w_is_rem = funct3[2] & funct3[1];
   // Remainder sign follows the dividend; everything else uses the xor.
   assign w_neg_rec = w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b);

   assign w_div0 = w_is_div & (SrcB == '0);
   assign w_ovf  = ((funct3 == 3'b100) | (funct3 == 3'b110)) &
                   (SrcA == {1'b1, {(W-1){1'b0}}}) & (SrcB == '1);
   assign w_fast = w_div0 ? (w_is_rem ? SrcA : '1)
                          : (w_is_rem ? '0 : SrcA);

   // Multiply step: add multiplicand into the high half, shift right.
   assign w_msum = {1'b0, r_acc[2*W-1:W]} +
                   {1'b0, (r_opb[0] ? r_opa : '0)};

   // Divide step: shift next dividend bit into the partial remainder.
   assign w_rsh = {r_acc[2*W-1:W], r_opa[W-1]};
   assign w_ge  = (w_rsh >= {1'b0, r_opb});
   assign w_sub = w_rsh[W-1:0] - r_opb;

   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_dsel = r_f3[1] ? r_acc[2*W-1:W] : r_acc[W-1:0];
   assign w_dres = r_neg ? -w_dsel : w_dsel;
   assign w_fix  = r_f3[2] ? w_dres :
                   (r_f3[1:0] == 2'b00) ? w_prod[W-1:0] :
                   w_prod[2*W-1:W];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_f3     <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start & ~kill) begin
                  r_f3   <= funct3;
                  r_busy <= 1'b1;
                  if (w_div0 | w_ovf) begin
                     r_result <= w_fast;
                     r_done   <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_opa   <= w_mag_a;
                     r_opb   <= w_mag_b;
                     r_neg   <= w_neg_rec;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (kill) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  if (!r_f3[2]) begin
                     r_acc <= {w_msum, r_acc[W-1:1]};
                     r_opb <= r_opb >> 1;
                  end else begin
                     r_acc[2*W-1:W] <= w_ge ? w_sub : w_rsh[W-1:0];
                     r_acc[W-1:0]   <= {r_acc[W-2:0], w_ge};
                     r_opa          <= r_opa << 1;
                  end
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
                  if (r_cnt == LAST) r_state <= FIX;
               end
            end
            FIX: begin
               if (kill) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_result <= w_fix;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign Result = r_result;
   assign stall  = (start & (r_state == IDLE)) |
                   (r_state == CALC) | (r_state == FIX);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: directed bench for muldiv_seq_ctrl.
// Drives RV32M ops and checks results, latency, kill and reset.
module tb_muldiv_seq_ctrl;

   localparam int W = 32;
   localparam int NLAT = W + 1;

   logic         clk = 1'b0;
   logic         reset, start, kill;
   logic [2:0]   funct3;
   logic [W-1:0] SrcA, SrcB;
   logic         busy, stall, done;
   logic [W-1:0] Result;

   int n_vec = 0;
   int n_err = 0;

   muldiv_seq_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .SrcA(SrcA), .SrcB(SrcB), .kill(kill),
      .busy(busy), .stall(stall), .done(done), .Result(Result)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int exp_lat, input string nm);
      int lat;
      funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
         n_err++;
         $display("FAIL %s stall_on_start: got %b want 1", nm, stall);
      end
      tick();
      start = 1'b0;
      SrcA = $urandom; SrcB = $urandom; funct3 = 3'($urandom);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s busy: got %b want 1", nm, busy);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 80) begin
         tick();
         lat++;
      end
      n_vec++;
      if (lat !== exp_lat) begin
         n_err++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      n_vec++;
      if (Result !== exp) begin
         n_err++;
         $display("FAIL %s result: got %h want %h", nm, Result, exp);
      end
      n_vec++;
      if (stall !== 1'b0) begin
         n_err++;
         $display("FAIL %s stall_in_done: got %b want 0", nm, stall);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle_after: got busy=%b done=%b want 0 0",
                  nm, busy, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; kill = 1'b0;
      funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'd6;
      tick(); tick(); tick();
      start = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== '0 ||
          stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset: got busy=%b done=%b res=%h stall=%b want 0",
                  busy, done, Result, stall);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      do_op(3'b000, 32'd7, 32'd6, 32'd42, NLAT, "mul_7x6");
      do_op(3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, NLAT, "mul_neg");
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, NLAT, "mulh");
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NLAT,
            "mulhu");
      do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, NLAT, "mulhsu");
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NLAT,
            "mulh_min");
   endtask

   task automatic test_div();
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NLAT, "div_m7_2");
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NLAT, "rem_m7_2");
      do_op(3'b101, 32'd100, 32'd7, 32'd14, NLAT, "divu_100_7");
      do_op(3'b111, 32'd100, 32'd7, 32'd2, NLAT, "remu_100_7");
   endtask

   task automatic test_special();
      do_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "div_by0");
      do_op(3'b110, 32'd5, 32'd0, 32'd5, 0, "rem_by0");
      do_op(3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,
            "div_ovf");
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem_ovf");
   endtask

   task automatic test_kill();
      logic [W-1:0] prev;
      logic seen;
      prev = Result;
      funct3 = 3'b000; SrcA = 32'h1234; SrcB = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== prev ||
          stall !== 1'b0) begin
         n_err++;
         $display("FAIL kill_calc: got busy=%b done=%b res=%h want 0 0 %h",
                  busy, done, Result, prev);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL kill_no_done: got done pulse want none");
      end
      funct3 = 3'b000; SrcA = 32'd4; SrcB = 32'd4;
      start = 1'b1; kill = 1'b1;
      tick();
      start = 1'b0; kill = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || Result !== prev) begin
         n_err++;
         $display("FAIL kill_idle: got busy=%b res=%h want 0 %h",
                  busy, Result, prev);
      end
      do_op(3'b000, 32'd3, 32'd3, 32'd9, NLAT, "mul_after_kill");
   endtask

   task automatic test_reset_mid();
      funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== '0 ||
          stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: got busy=%b done=%b res=%h stall=%b",
                  busy, done, Result, stall);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      funct3 = 3'b000; SrcA = 32'd11; SrcB = 32'd13; start = 1'b1;
      tick();
      lat = 0;
      while (done !== 1'b1 && lat < 80) begin
         tick();
         lat++;
      end
      n_vec++;
      if (lat !== NLAT || Result !== 32'd143) begin
         n_err++;
         $display("FAIL b2b_first: got lat=%0d res=%h want %0d 0000008f",
                  lat, Result, NLAT);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_idle: got busy=%b done=%b stall=%b want 0 0 1",
                  busy, done, stall);
      end
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_accept: got busy=%b want 1", busy);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 80) begin
         tick();
         lat++;
      end
      n_vec++;
      if (lat !== NLAT || Result !== 32'd143) begin
         n_err++;
         $display("FAIL b2b_second: got lat=%0d res=%h want %0d 0000008f",
                  lat, Result, NLAT);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions, placed in the execute stage beside the single-cycle ALU.
- Accepts one operation per start pulse and iterates a shared shift/add-subtract datapath over DATA_WIDTH cycles.
- Stalls the pipeline while busy and returns a 32-bit result with a one-cycle done pulse.
- Decode steers funct7=0000001 R-type instructions here instead of the ALU.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand (dividend / multiplicand).
- SrcB  input  DATA_WIDTH  rs2 operand (divisor / multiplier).
- kill  input  1  pipeline flush; aborts any operation in progress.
- busy  output  1  high in every state except IDLE.
- stall  output  1  combinational: (start & IDLE) | CALC | FIX.
- done  output  1  one-cycle pulse; Result is valid while high.
- Result  output  DATA_WIDTH  final result; held until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, Result=0, counter=0, internal registers=0. Reset overrides start and kill, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, normal case:
  - Latch funct3 and operand magnitudes.
  - Signed operands: DIV/REM/MULH use both; MULHSU uses SrcA only. Record result sign.
  - Clear the 2*DATA_WIDTH accumulator, set counter=0, go to CALC.
- IDLE, start=1, special cases (go directly to DONE, no CALC):
  - DIV/DIVU with SrcB=0: quotient = all ones.
  - REM/REMU with SrcB=0: remainder = SrcA.
  - DIV with SrcA=0x80000000 and SrcB=0xFFFFFFFF: quotient = 0x80000000.
  - REM with the same operands: remainder = 0.
- CALC: one iteration per cycle, DATA_WIDTH iterations (counter 0..DATA_WIDTH-1).
  - Multiply: radix-2 shift-add, unsigned on magnitudes.
  - Divide: restoring shift-subtract, unsigned on magnitudes.
  - After the counter reaches DATA_WIDTH-1, go to FIX.
- FIX: apply 2's-complement negation when the recorded sign requires it, then select the output:
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; sign follows the dividend.
  - Register Result; go to DONE.
- DONE: done=1 for exactly one cycle; start is ignored; unconditional return to IDLE.
- Latency (start sampled at edge 0):
  - Normal: done high in the cycle after edge DATA_WIDTH+1, i.e. DATA_WIDTH+2 cycles after the start cycle.
  - Special case: done high in the cycle after edge 0.
- stall drops in DONE so the pipeline advances in the same cycle it captures Result.
- kill: in CALC or FIX, go to IDLE next edge; no done pulse; Result keeps its previous value.
  - kill in IDLE blocks acceptance of a simultaneous start.
  - kill in DONE has no effect; the done pulse still occurs.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE; the minimum period is DATA_WIDTH+3 cycles.
- SrcA, SrcB and funct3 may change after acceptance without affecting the operation in progress.

Test Plan:
- Reset then MUL 7 x 6: start pulse -> stall high, done at cycle 34, Result=42, busy=0 afterwards.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> Result=0; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> Result=0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 with x=5 -> Result=0xFFFFFFFF with done one cycle after start; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both on the fast path.
- Assert kill at CALC iteration 10 -> no done pulse, IDLE next cycle, Result unchanged; a new MUL 3 x 3 then completes with Result=9.
- Assert reset at CALC iteration 20 -> all outputs 0 next cycle; start held high through DONE is not re-accepted until IDLE.
